// File: rtl/laser_shot_scheduler_pkg.sv
// Shared definitions for the laser shot scheduler: register map, control and
// status bit positions, and the sequencer state encoding.
package laser_shot_scheduler_pkg;

  // Register addresses on the Avalon-MM slave
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD  = 3'd2;
  localparam logic [2:0] ADDR_BURST   = 3'd3;
  localparam logic [2:0] ADDR_TIMEOUT = 3'd4;
  localparam logic [2:0] ADDR_HITS    = 3'd5;
  localparam logic [2:0] ADDR_MISSES  = 3'd6;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_ABORT  = 2;
  localparam int CTRL_IRQ_EN = 3;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  // Shot sequencer states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FIRE = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/laser_shot_scheduler_pulse_sync_edge.sv
// Synchronizes an asynchronous pulse into the clock domain and emits a
// registered one-cycle strobe on its rising edge. The strobe appears
// SYNC_STAGES+1 clocks after the input rises.
module pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  // Shift the input through the synchronizer chain and register the edge strobe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/laser_shot_scheduler.sv
// Laser shot scheduler: fires a burst of one-cycle laser triggers at a fixed
// period, waits for the start comparator after each shot, tallies hits and
// misses, and flags completion through a sticky done bit and irq.
module laser_shot_scheduler
  import laser_shot_scheduler_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 4
) (
  input  logic        avmms_clk,
  input  logic        avmms_reset,
  input  logic        avmms_cs,
  input  logic [2:0]  avmms_address,
  input  logic        avmms_write,
  input  logic [31:0] avmms_writedata,
  input  logic        avmms_read,
  output logic [31:0] avmms_readdata,
  input  logic        comparator,
  output logic        fire,
  output logic        busy,
  output logic        irq
);

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  // Programmed registers
  logic             r_cont;
  logic             r_irq_en;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_burst;
  logic [CNT_W-1:0] r_timeout;
  logic             r_done;
  logic             r_aborted;

  // Working copies taken at start, plus run-time counters
  logic [CNT_W-1:0] r_period_w;
  logic [CNT_W-1:0] r_burst_w;
  logic [CNT_W-1:0] r_timeout_w;
  logic [CNT_W-1:0] r_period_cnt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] r_shots;
  logic [CNT_W-1:0] r_hits;
  logic [CNT_W-1:0] r_misses;

  state_t r_state;
  state_t w_state_next;

  logic             w_wr;
  logic             w_rd;
  logic             w_start;
  logic             w_abort;
  logic             w_edge;
  logic             w_fire;
  logic             w_hit;
  logic             w_miss;
  logic             w_start_acc;
  logic             w_shot;
  logic             w_done_set;
  logic [CNT_W-1:0] w_eff_period;
  logic [31:0]      w_rd_mux;

  assign w_wr    = avmms_cs & avmms_write;
  assign w_rd    = avmms_cs & avmms_read;
  assign w_start = w_wr && (avmms_address == ADDR_CTRL) && avmms_writedata[CTRL_START];
  assign w_abort = w_wr && (avmms_address == ADDR_CTRL) && avmms_writedata[CTRL_ABORT];

  // Short periods are raised to the minimum the sequencer can honour
  assign w_eff_period = (r_period_w < MIN_P) ? MIN_P : r_period_w;

  pulse_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_start_sync (
    .i_clk   (avmms_clk),
    .i_rst   (avmms_reset),
    .i_async (comparator),
    .o_rise  (w_edge)
  );

  // Capture CPU writes to the configuration registers
  always_ff @(posedge avmms_clk or posedge avmms_reset) begin
    if (avmms_reset) begin
      r_cont    <= 1'b0;
      r_irq_en  <= 1'b0;
      r_period  <= MIN_P;
      r_burst   <= '0;
      r_timeout <= '0;
    end else if (w_wr) begin
      case (avmms_address)
        ADDR_CTRL: begin
          r_cont   <= avmms_writedata[CTRL_CONT];
          r_irq_en <= avmms_writedata[CTRL_IRQ_EN];
        end
        ADDR_PERIOD:  r_period  <= avmms_writedata[CNT_W-1:0];
        ADDR_BURST:   r_burst   <= avmms_writedata[CNT_W-1:0];
        ADDR_TIMEOUT: r_timeout <= avmms_writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // Sticky done/aborted flags; a new event in the same cycle beats a W1C clear
  always_ff @(posedge avmms_clk or posedge avmms_reset) begin
    if (avmms_reset) begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      if (w_wr && (avmms_address == ADDR_STATUS) && avmms_writedata[STAT_DONE]) r_done <= 1'b0;
      if (w_wr && (avmms_address == ADDR_STATUS) && avmms_writedata[STAT_ABORTED]) r_aborted <= 1'b0;
      if (w_done_set) r_done <= 1'b1;
      if (w_abort) r_aborted <= 1'b1;
    end
  end

  // Sequencer state register
  always_ff @(posedge avmms_clk or posedge avmms_reset) begin
    if (avmms_reset) r_state <= S_IDLE;
    else             r_state <= w_state_next;
  end

  // Sequencer next state and per-cycle event strobes; abort overrides everything
  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    w_hit        = 1'b0;
    w_miss       = 1'b0;
    w_start_acc  = 1'b0;
    w_shot       = 1'b0;
    w_done_set   = 1'b0;
    if (w_abort) begin
      w_state_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            w_start_acc  = 1'b1;
            w_state_next = (r_burst == '0) ? S_DONE : S_FIRE;
          end
        end
        S_FIRE: begin
          w_fire       = 1'b1;
          w_state_next = S_WAIT;
        end
        S_WAIT: begin
          if (w_edge && (r_wait_cnt <= r_timeout_w)) begin
            w_hit        = 1'b1;
            w_state_next = S_HOLD;
          end else if (r_wait_cnt >= r_timeout_w) begin
            w_miss       = 1'b1;
            w_state_next = S_HOLD;
          end
        end
        S_HOLD: begin
          // period_cnt counts cycles since the fire cycle, so leaving HOLD at
          // PERIOD-1 puts the next fire exactly PERIOD cycles after the last
          if (r_period_cnt >= (w_eff_period - ONE)) begin
            w_shot = 1'b1;
            if (((r_shots + ONE) == r_burst_w) && !r_cont) w_state_next = S_DONE;
            else                                           w_state_next = S_FIRE;
          end
        end
        S_DONE: begin
          w_done_set   = 1'b1;
          w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Shadow registers, period/wait timers, shot index and saturating tallies
  always_ff @(posedge avmms_clk or posedge avmms_reset) begin
    if (avmms_reset) begin
      r_period_w   <= MIN_P;
      r_burst_w    <= '0;
      r_timeout_w  <= '0;
      r_period_cnt <= '0;
      r_wait_cnt   <= '0;
      r_shots      <= '0;
      r_hits       <= '0;
      r_misses     <= '0;
    end else begin
      if (w_start_acc) begin
        r_period_w  <= r_period;
        r_burst_w   <= r_burst;
        r_timeout_w <= r_timeout;
        r_hits      <= '0;
        r_misses    <= '0;
        r_shots     <= '0;
      end
      if (r_state == S_FIRE) begin
        r_period_cnt <= ONE;
        r_wait_cnt   <= ONE;
      end else if (r_state != S_IDLE) begin
        r_period_cnt <= r_period_cnt + ONE;
        r_wait_cnt   <= r_wait_cnt + ONE;
      end
      if (w_hit && (r_hits != '1)) r_hits <= r_hits + ONE;
      if (w_miss && (r_misses != '1)) r_misses <= r_misses + ONE;
      if (w_shot) r_shots <= ((r_shots + ONE) == r_burst_w) ? '0 : (r_shots + ONE);
    end
  end

  // Read-data multiplexer; write-only pulse bits read back as zero
  always_comb begin
    w_rd_mux = '0;
    case (avmms_address)
      ADDR_CTRL: begin
        w_rd_mux[CTRL_CONT]   = r_cont;
        w_rd_mux[CTRL_IRQ_EN] = r_irq_en;
      end
      ADDR_STATUS: begin
        w_rd_mux[STAT_BUSY]    = (r_state != S_IDLE);
        w_rd_mux[STAT_DONE]    = r_done;
        w_rd_mux[STAT_ABORTED] = r_aborted;
      end
      ADDR_PERIOD:  w_rd_mux = 32'(r_period);
      ADDR_BURST:   w_rd_mux = 32'(r_burst);
      ADDR_TIMEOUT: w_rd_mux = 32'(r_timeout);
      ADDR_HITS:    w_rd_mux = 32'(r_hits);
      ADDR_MISSES:  w_rd_mux = 32'(r_misses);
      default:      w_rd_mux = '0;
    endcase
  end

  // Registered read data, updated only on a selected read
  always_ff @(posedge avmms_clk or posedge avmms_reset) begin
    if (avmms_reset)  avmms_readdata <= '0;
    else if (w_rd)    avmms_readdata <= w_rd_mux;
  end

  assign fire = w_fire;
  assign busy = (r_state != S_IDLE);
  assign irq  = r_done & r_irq_en;

endmodule

// File: tb/tb_laser_shot_scheduler.sv
// Directed bench for laser_shot_scheduler with an echo model on the
// comparator input and a scoreboard of expected register reads and spacings.
module tb_laser_shot_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic        wr = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        rd = 1'b0;
  logic [31:0] rdata;
  logic        comparator;
  logic        fire;
  logic        busy;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int idle_cyc = 0;

  // Echo model controls (written by the main sequence only)
  bit echo_en    = 1'b0;
  int echo_delay = 0;

  int fire_times[$];
  string       sb_tag[$];
  logic [31:0] sb_val[$];

  laser_shot_scheduler #(
    .CNT_W(32), .SYNC_STAGES(2), .MIN_PERIOD(4)
  ) dut (
    .avmms_clk       (clk),
    .avmms_reset     (rst),
    .avmms_cs        (cs),
    .avmms_address   (addr),
    .avmms_write     (wr),
    .avmms_writedata (wdata),
    .avmms_read      (rd),
    .avmms_readdata  (rdata),
    .comparator      (comparator),
    .fire            (fire),
    .busy            (busy),
    .irq             (irq)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Fire monitor and comparator echo: rises echo_delay cycles after a fire, high for 3 cycles
  initial begin
    int echo_cnt;
    int hold_cnt;
    echo_cnt = 0;
    hold_cnt = 0;
    comparator = 1'b0;
    forever begin
      @(negedge clk);
      if (echo_cnt > 0) begin
        echo_cnt--;
        if (echo_cnt == 0) begin
          comparator = 1'b1;
          hold_cnt = 3;
        end
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) comparator = 1'b0;
      end
      if (fire === 1'b1) begin
        fire_times.push_back(cyc);
        if (echo_en) echo_cnt = echo_delay;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_tag.push_back(tag);
    sb_val.push_back(val);
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    if (sb_val.size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
    else chk(sb_tag.pop_front(), obs, sb_val.pop_front());
  endtask

  task automatic av_write(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    step();
    cs = 1'b0; wr = 1'b0; wdata = 32'd0;
  endtask

  task automatic av_read_expect(input logic [2:0] a, input logic [31:0] exp, input string tag);
    sb_push(tag, exp);
    cs = 1'b1; rd = 1'b1; addr = a;
    step();
    cs = 1'b0; rd = 1'b0;
    sb_pop_check(rdata);
  endtask

  task automatic wait_fires(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (fire_times.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, fire_times.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy === 1'b1 && k < budget) begin
      step();
      k++;
    end
    idle_cyc = cyc;
    chk(tag, busy, 1'b0);
  endtask

  // Compare n-1 fire spacings against expectations queued before the burst
  task automatic check_spacing(input int n);
    for (int i = 1; i < n; i++) begin
      logic [31:0] o;
      o = (i < fire_times.size()) ? 32'(fire_times[i] - fire_times[i-1]) : 32'hFFFF_FFFF;
      sb_pop_check(o);
    end
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset values
    chk("reset_fire", fire, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_irq", irq, 1'b0);
    av_read_expect(3'd0, 32'd0, "reset_ctrl");
    av_read_expect(3'd1, 32'd0, "reset_status");
    av_read_expect(3'd2, 32'd4, "reset_period");
    av_read_expect(3'd3, 32'd0, "reset_burst");

    // 1: three hits at period 50
    av_write(3'd2, 32'd50);
    av_write(3'd3, 32'd3);
    av_write(3'd4, 32'd20);
    echo_en = 1'b1; echo_delay = 13;
    fire_times.delete();
    sb_push("t1_spacing1", 32'd50);
    sb_push("t1_spacing2", 32'd50);
    av_write(3'd0, 32'h9);
    wait_idle(400, "t1_idle");
    chk("t1_fire_count", fire_times.size(), 3);
    check_spacing(3);
    av_read_expect(3'd5, 32'd3, "t1_hits");
    av_read_expect(3'd6, 32'd0, "t1_misses");
    av_read_expect(3'd1, 32'h2, "t1_status");
    chk("t1_irq", irq, 1'b1);

    // 2: no echo, three misses
    av_write(3'd1, 32'h6);
    av_read_expect(3'd1, 32'd0, "t2_status_cleared");
    chk("t2_irq_cleared", irq, 1'b0);
    echo_en = 1'b0;
    fire_times.delete();
    sb_push("t2_spacing1", 32'd50);
    sb_push("t2_spacing2", 32'd50);
    av_write(3'd0, 32'h9);
    wait_idle(400, "t2_idle");
    chk("t2_fire_count", fire_times.size(), 3);
    check_spacing(3);
    av_read_expect(3'd5, 32'd0, "t2_hits");
    av_read_expect(3'd6, 32'd3, "t2_misses");

    // 3: timeout longer than period stretches spacing to timeout+2
    av_write(3'd1, 32'h6);
    av_write(3'd2, 32'd10);
    av_write(3'd4, 32'd30);
    av_write(3'd3, 32'd2);
    fire_times.delete();
    sb_push("t3_spacing", 32'd32);
    av_write(3'd0, 32'h1);
    wait_idle(400, "t3_idle");
    chk("t3_fire_count", fire_times.size(), 2);
    check_spacing(2);
    chk("t3_done_latency", (fire_times.size() == 2) ? 32'(idle_cyc - fire_times[1]) : 32'hFFFF_FFFF, 32'd33);
    av_read_expect(3'd1, 32'h2, "t3_status");
    av_read_expect(3'd6, 32'd2, "t3_misses");
    chk("t3_irq_masked", irq, 1'b0);

    // 4: continuous run aborted 5 cycles after the 4th fire
    av_write(3'd1, 32'h6);
    av_write(3'd2, 32'd20);
    av_write(3'd4, 32'd10);
    fire_times.delete();
    av_write(3'd0, 32'h3);
    wait_fires(4, 200, "t4_four_fires");
    repeat (5) step();
    av_write(3'd0, 32'h4);
    chk("t4_busy_after_abort", busy, 1'b0);
    repeat (40) step();
    chk("t4_no_more_fire", fire_times.size(), 4);
    av_read_expect(3'd1, 32'h4, "t4_status");
    av_read_expect(3'd5, 32'd0, "t4_hits");
    av_read_expect(3'd6, 32'd3, "t4_misses");

    // Start and abort in one write: abort wins, nothing fires
    av_write(3'd1, 32'h6);
    fire_times.delete();
    av_write(3'd0, 32'h5);
    repeat (20) step();
    chk("t4b_no_fire", fire_times.size(), 0);
    av_read_expect(3'd1, 32'h4, "t4b_status");

    // 5: echo edge exactly at wait_cnt==TIMEOUT is a hit; one cycle later is a miss
    av_write(3'd1, 32'h6);
    av_write(3'd2, 32'd20);
    av_write(3'd4, 32'd8);
    av_write(3'd3, 32'd1);
    echo_en = 1'b1; echo_delay = 5;
    av_write(3'd0, 32'h1);
    wait_idle(100, "t5_idle_a");
    av_read_expect(3'd5, 32'd1, "t5_edge_at_timeout_hit");
    av_read_expect(3'd6, 32'd0, "t5_edge_at_timeout_miss");
    echo_delay = 6;
    av_write(3'd0, 32'h1);
    wait_idle(100, "t5_idle_b");
    av_read_expect(3'd5, 32'd0, "t5_late_edge_hit");
    av_read_expect(3'd6, 32'd1, "t5_late_edge_miss");
    repeat (6) step();

    // PERIOD below the minimum is clamped
    echo_en = 1'b0;
    av_write(3'd2, 32'd2);
    av_write(3'd4, 32'd1);
    av_write(3'd3, 32'd3);
    av_read_expect(3'd2, 32'd2, "t5_period_readback");
    fire_times.delete();
    sb_push("t5_clamp_spacing1", 32'd4);
    sb_push("t5_clamp_spacing2", 32'd4);
    av_write(3'd0, 32'h1);
    wait_idle(100, "t5_idle_c");
    chk("t5_clamp_fire_count", fire_times.size(), 3);
    check_spacing(3);

    // 6: asynchronous reset during a fire cycle
    av_write(3'd2, 32'd50);
    av_write(3'd4, 32'd20);
    av_write(3'd3, 32'd3);
    av_write(3'd0, 32'h8);
    chk("t6_irq_before", irq, 1'b1);
    fire_times.delete();
    av_write(3'd0, 32'h9);
    wait_fires(1, 20, "t6_first_fire");
    chk("t6_fire_before_reset", fire, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_fire_async", fire, 1'b0);
    chk("t6_busy_async", busy, 1'b0);
    chk("t6_irq_async", irq, 1'b0);
    step();
    rst = 1'b0;
    step();
    av_read_expect(3'd0, 32'd0, "t6_ctrl");
    av_read_expect(3'd1, 32'd0, "t6_status");
    av_read_expect(3'd2, 32'd4, "t6_period");
    av_read_expect(3'd3, 32'd0, "t6_burst");
    av_read_expect(3'd4, 32'd0, "t6_timeout");
    av_read_expect(3'd5, 32'd0, "t6_hits");
    av_read_expect(3'd6, 32'd0, "t6_misses");
    av_read_expect(3'd7, 32'd0, "t6_addr7");

    // BURST=0 start completes at once without firing
    fire_times.delete();
    av_write(3'd0, 32'h9);
    repeat (10) step();
    chk("t6_burst0_no_fire", fire_times.size(), 0);
    av_read_expect(3'd1, 32'h2, "t6_burst0_status");
    chk("t6_burst0_irq", irq, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
